// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with valid/ready request and response channels and one operation in flight.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   m_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CntW-1:0]   cnt_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;

    logic            is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_div   = req_op_i[2];
        a_signed = is_div ? ~req_op_i[0] : (req_op_i[1:0] != 2'd3);
        b_signed = is_div ? ~req_op_i[0] : ~req_op_i[1];
        sa       = a_signed & req_a_i[XLEN-1];
        sb       = b_signed & req_b_i[XLEN-1];
        a_mag    = sa ? -req_a_i : req_a_i;
        b_mag    = sb ? -req_b_i : req_b_i;
        div_zero = is_div && (req_b_i == '0);
        div_ovf  = is_div && !req_op_i[0] && (req_a_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (req_b_i == '1);
        // Overflow quotient equals the dividend itself (most negative value)
        if (div_zero) special_res = req_op_i[1] ? req_a_i : '1;
        else          special_res = req_op_i[1] ? '0 : req_a_i;
    end

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    // acc_q holds {partial product high, multiplier} or {remainder, quotient/dividend}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_q};
        if (!op_q[2]) begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end else if (div_shift >= {1'b0, m_q}) begin
            acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        prod = q_neg_q ? -acc_q : acc_q;
        quo  = q_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = r_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:             final_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = quo;
            default:          final_res = rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            op_q         <= '0;
            m_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else if (flush_i) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        op_q    <= req_op_i;
                        q_neg_q <= sa ^ sb;
                        r_neg_q <= sa;
                        cnt_q   <= '0;
                        m_q     <= is_div ? b_mag : a_mag;
                        acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        if (div_zero || div_ovf) begin
                            state_q     <= StDone;
                            resp_data_q <= special_res;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (cnt_q == CntW'(XLEN)) begin
                        state_q      <= StDone;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= final_res;
                    end else begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // Special cases enter with valid low and raise it one cycle later
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (resp_ready_i) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, special cases, backpressure, flush, reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .flush_i     (flush),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_data_o (resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(tag, op, a, b);
        wait_resp(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, resp_data, exp);
        @(posedge clk);
        #1;
        check({tag, "_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int  lat;
        logic seen;

        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", resp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, 33);
        run("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu_neg", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
        run("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run("divu_big", 3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);

        run("div_zero", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("remu_zero", 3'd7, 32'd5, 32'd0, 32'd5, 1);
        run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Backpressure: response must hold while consumer stalls
        resp_ready = 1'b0;
        issue("bp", 3'd0, 32'd3, 32'd5);
        wait_resp(lat);
        check("bp_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(resp_valid), 32'd1);
            check("bp_hold_data", resp_data, 32'd15);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drop", 32'(resp_valid), 32'd0);
        check("bp_ready", 32'(req_ready), 32'd1);

        // Flush at cnt=10 of a DIVU: no response may follow
        issue("flush", 3'd5, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ready", 32'(req_ready), 32'd1);
        check("flush_valid", 32'(resp_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        check("flush_no_resp", 32'(seen), 32'd0);
        run("post_flush", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // Asynchronous reset mid-calculation
        issue("rst_mid", 3'd0, 32'd7, 32'd6);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_valid", 32'(resp_valid), 32'd0);
        check("rst_mid_data", resp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 3'd0, 32'd7, 32'd6, 32'd42, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
